// File: rtl/booth_mult_pkg.sv
// Shared types and build-dependent constants for the sequential Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a. Build option BOOTH_RADIX4_EN selects radix-4 recoding.
package booth_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

`ifdef BOOTH_RADIX4_EN
    // Two multiplier bits retired per iteration.
    localparam int BOOTH_SHIFT = 2;
`else
    // One multiplier bit retired per iteration.
    localparam int BOOTH_SHIFT = 1;
`endif

    // Number of CALC iterations for the active build.
    function automatic int booth_iter(input int width);
`ifdef BOOTH_RADIX4_EN
        return (width + 2) / 2;
`else
        return width + 1;
`endif
    endfunction

    // Width of the internal multiplier shift register. Radix-2 only needs one
    // extension bit; radix-4 consumes pairs, so it carries the full extension.
    function automatic int booth_qw(input int width);
`ifdef BOOTH_RADIX4_EN
        return width + 2;
`else
        return width + 1;
`endif
    endfunction

endpackage

// File: rtl/booth_mult_seq_pp_sel.sv
// Booth partial-product selector: maps a 3-bit recoding window to 0, +/-M, +/-2M.
// Latency: combinational.
// Backpressure: none. A radix-2 window {b,b,c} only ever hits the 0/+/-M codes.
module booth_pp_sel #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       i_win,
    input  logic [WIDTH+1:0] i_mcand,
    output logic [WIDTH+1:0] o_pp
);

    // Radix-4 modified Booth digit table; 2M is a left shift of the extended multiplicand.
    always_comb begin
        o_pp = '0;
        case (i_win)
            3'b001, 3'b010: o_pp = i_mcand;
            3'b011:         o_pp = {i_mcand[WIDTH:0], 1'b0};
            3'b100:         o_pp = -{i_mcand[WIDTH:0], 1'b0};
            3'b101, 3'b110: o_pp = -i_mcand;
            default:        o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, signed/unsigned per op; radix-4 when BOOTH_RADIX4_EN is defined.
// Latency: start-sample edge plus ITER CALC edges (ITER = WIDTH+1, or (WIDTH+2)/2 in radix-4).
// Backpressure: start sampled only in IDLE; result held in DONE until start is seen low.
module booth_mult_seq
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     num_1,
    input  logic [WIDTH-1:0]     num_2,
    output logic                 busy,
    output logic                 mult_ready,
    output logic [2*WIDTH-1:0]   mult
);

    localparam int XW   = WIDTH + 2;           // accumulator / multiplicand width
    localparam int ITER = booth_iter(WIDTH);
    localparam int SH   = BOOTH_SHIFT;
    localparam int QW   = booth_qw(WIDTH);     // multiplier shift register width
    localparam int SW   = XW + SH;             // guard bits so the sum never wraps
    localparam int CW   = $clog2(ITER + 1);

    booth_state_t       r_state;
    booth_state_t       w_state_nxt;
    logic [XW-1:0]      r_mcand;
    logic [XW-1:0]      r_acc;
    logic [QW-1:0]      r_q;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mult;

    logic [XW-1:0]      w_mcand_ext;
    logic [QW-1:0]      w_mplr_ext;
    logic [2:0]         w_win;
    logic [XW-1:0]      w_pp;
    logic [SW-1:0]      w_sum;
    logic [XW-1:0]      w_acc_nxt;
    logic [QW-1:0]      w_q_nxt;
    logic               w_last;

    // Operand extension: sign-extend for signed ops, zero-extend otherwise, so
    // unsigned operands with MSB set are still exact.
    assign w_mcand_ext = is_signed ? {{2{num_1[WIDTH-1]}}, num_1} : {2'b00, num_1};
    assign w_mplr_ext  = is_signed ? {{(QW-WIDTH){num_2[WIDTH-1]}}, num_2}
                                   : {{(QW-WIDTH){1'b0}}, num_2};

`ifdef BOOTH_RADIX4_EN
    assign w_win = {r_q[1:0], r_qm1};
`else
    assign w_win = {r_q[0], r_q[0], r_qm1};
`endif

    booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .i_win   (w_win),
        .i_mcand (r_mcand),
        .o_pp    (w_pp)
    );

    // Add in a widened domain, then arithmetic-shift {acc, q, qm1} right by SH.
    assign w_sum     = {{SH{r_acc[XW-1]}}, r_acc} + {{SH{w_pp[XW-1]}}, w_pp};
    assign w_acc_nxt = w_sum[SW-1:SH];
    assign w_q_nxt   = {w_sum[SH-1:0], r_q[QW-1:SH]};
    assign w_last    = (r_cnt == CW'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mult_ready  = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                mult_ready = 1'b1;
                if (!start) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, Booth iteration and product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_mult  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_mcand <= w_mcand_ext;
                    r_acc   <= '0;
                    r_q     <= w_mplr_ext;
                    r_qm1   <= 1'b0;
                    r_cnt   <= CW'(ITER);
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[SH-1];
                    r_cnt <= r_cnt - CW'(1);
                    // Product is the low 2*WIDTH bits of {acc, q} after the last step.
                    if (w_last) r_mult <= {w_acc_nxt[2*WIDTH-QW-1:0], w_q_nxt};
                end
                default: ;
            endcase
        end
    end

    assign mult = r_mult;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int IT8  = 5;
    localparam int IT16 = 9;
`else
    localparam int IT8  = 9;
    localparam int IT16 = 17;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_signed;
    logic [7:0]  num_1, num_2;
    logic        busy, mult_ready;
    logic [15:0] mult;

    logic        start16, is_signed16;
    logic [15:0] num_1_16, num_2_16;
    logic        busy16, mult_ready16;
    logic [31:0] mult16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .num_1(num_1), .num_2(num_2), .busy(busy), .mult_ready(mult_ready), .mult(mult)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .is_signed(is_signed16),
        .num_1(num_1_16), .num_2(num_2_16), .busy(busy16), .mult_ready(mult_ready16),
        .mult(mult16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 8-bit operation: checks busy, latency, product; optionally leaves start high.
    task automatic op8(input string tag, input bit sg, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp, input bit hold);
        int lat;
        @(negedge clk);
        start = 1'b1; is_signed = sg; num_1 = a; num_2 = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        num_1 = ~a; num_2 = ~b; is_signed = ~sg;   // must be ignored during CALC
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!mult_ready && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, IT8);
        chk({tag, "_prod"}, mult, exp);
        chk({tag, "_busy_done"}, busy, 0);
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, "_rdy_drop"}, mult_ready, 0);
            chk({tag, "_retain"}, mult, exp);
        end
    endtask

    task automatic op16(input string tag, input bit sg, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        start16 = 1'b1; is_signed16 = sg; num_1_16 = a; num_2_16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!mult_ready16 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, IT16);
        chk({tag, "_prod"}, mult16, exp);
        @(posedge clk); #1;
        chk({tag, "_rdy_drop"}, mult_ready16, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit          seen;
        bit          sg;
        logic [15:0] ra, rb;
        longint      sa, sb;
        logic [63:0] p;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; num_1 = '0; num_2 = '0;
        start16 = 1'b0; is_signed16 = 1'b0; num_1_16 = '0; num_2_16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", mult_ready, 0);
        chk("rst_mult", mult, 0);
        chk("rst_mult16", mult16, 0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1
        op8("s_0x37", 1, 8'd0, 8'd37, 16'd0, 0);
        op8("s_53x46", 1, 8'd53, 8'd46, 16'd2438, 0);
        // Scenario 2
        op8("s_m8xm2", 1, 8'hF8, 8'hFE, 16'd16, 0);
        op8("s_m128x127", 1, 8'h80, 8'h7F, 16'hC080, 0);
        op8("s_m128xm128", 1, 8'h80, 8'h80, 16'd16384, 0);
        // Scenario 3
        op8("u_255x255", 0, 8'hFF, 8'hFF, 16'd65025, 0);
        op8("u_200x3", 0, 8'd200, 8'd3, 16'd600, 0);
        op8("s_m1xm1", 1, 8'hFF, 8'hFF, 16'd1, 0);
        op8("s_m56x3", 1, 8'd200, 8'd3, 16'hFF58, 0);

        // Scenario 4: start held through DONE
        op8("hold", 1, 8'd12, 8'd11, 16'd132, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", mult_ready, 1);
            chk("hold_busy", busy, 0);
            chk("hold_mult", mult, 132);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("hold_exit_ready", mult_ready, 0);
        chk("hold_exit_busy", busy, 0);

        // Scenario 5: reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; num_1 = 8'd7; num_2 = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", mult_ready, 0);
        chk("abort_mult", mult, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < IT8 + 3; i++) begin
            @(posedge clk); #1;
            if (mult_ready || busy) seen = 1'b1;
        end
        chk("abort_no_ready", seen, 0);
        op8("s_99x97", 1, 8'd99, 8'd97, 16'd9603, 0);

        // Scenario 6: WIDTH=16
        op16("w16_min_sq", 1, 16'h8000, 16'h8000, 32'h4000_0000);
        op16("w16_u_max", 0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        for (int i = 0; i < 1000; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            sa = sg ? longint'($signed(ra)) : longint'(ra);
            sb = sg ? longint'($signed(rb)) : longint'(rb);
            p  = 64'(sa * sb);
            op16("w16_rand", sg, ra, rb, p[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
